digit_scan_decoder4: RTL and testbench
======================================

Name: digit_scan_decoder4

Overview:
- Drives a 4-digit multiplexed 7-segment display from a 16-bit hex value (4 nibbles).
- Time-multiplexes the digits: a prescaled scan counter selects one digit at a time.
- The 2-bit digit index is decoded one-hot onto the anodes. This is the 2-to-4 decode direction, pairing with the lab's 4x2 encoders.
- The selected nibble is decoded to segments. Sits between the lab datapath and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; legal range ≥1; prescaler width $clog2(REFRESH_DIV) (min 1).
- ACTIVE_LOW_AN, 1, 1 = anode asserted low on the pins.
- ACTIVE_LOW_SEG, 1, 1 = segment lit when low.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en_i  input  1  scan enable; 0 blanks the display
- load_i  input  1  single-cycle strobe; captures data_i
- data_i  input  16  nibble k drives digit k (digit 0 = data_i[3:0])
- an  output  4  one-hot anode select, polarity per ACTIVE_LOW_AN
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW_SEG
- dig_idx  output  2  digit currently driven
- frame_done  output  1  1-cycle pulse on scan wrap 3→0

Behaviour:
- Reset (async, immediate): prescaler=0, idx=0, shadow=0, disp=0, pending=0, frame_done=0.
- Reset outputs: an all-off (4'b1111 active-low), seg all-off (7'b1111111 active-low), dig_idx=0.
- Prescaler: counts 0..REFRESH_DIV-1 while en_i=1. tick = (count==REFRESH_DIV-1), then count wraps to 0. With REFRESH_DIV=1, tick is asserted every cycle.
- On tick, idx ← idx+1 mod 4. Wrap 3→0 is a frame boundary: frame_done=1 for exactly that cycle.
- load_i:
  - shadow ← data_i; pending ← 1.
  - Repeated loads before a boundary: last value wins.
- Frame boundary with pending=1: disp ← shadow; pending ← 0. Frames never tear mid-scan.
- load_i on the same edge as a frame boundary: disp ← data_i directly (bypass); pending stays 0.
- Outputs are registered and computed from next-state (next idx, next disp), so an, seg and dig_idx change on the same edge as idx. No combinational path from inputs to pins.
- an = dec2to4(idx), one-hot, inverted if ACTIVE_LOW_AN.
- seg = hex7(disp[4*idx +: 4]), inverted if ACTIVE_LOW_SEG.
- Hex table (active-high, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- en_i=0:
  - prescaler and idx held at 0; an all-off, seg all-off.
  - frame_done never pulses.
  - load_i still captures to shadow and sets pending.
- en_i 0→1: scan restarts at digit 0. The first boundary occurs after 4·REFRESH_DIV cycles.
- Reset mid-frame discards pending data.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - digit k (k=3..1) has its anode forced off when disp nibble k and every higher nibble are 0.
  - digit 0 is always shown.
  - idx still steps through all 4 slots, so timing is unchanged.
- Undefined: all 4 digits are always displayed.

Decomposition:
- Package digit_scan_pkg:
  - NUM_DIGITS=4
  - typedef logic [6:0] seg_t
  - typedef logic [1:0] dig_idx_t
  - hex-to-segment constant table / function hex7()
- Sub-module dec2to4: 2-bit index + enable in, 4-bit one-hot out, registered-free combinational.
- Top holds the prescaler, idx, shadow/pending logic and output registers.

Test Plan:
- Reset: assert rst mid-scan (asynchronously, between edges) → an=4'b1111, seg=7'b1111111, dig_idx=0, frame_done=0 before the next edge.
- Load and scan: REFRESH_DIV=4, en_i=1, load 16'h1234.
  - After the next wrap: an=1110, seg=7'b0011001 ("4").
  - 4 cycles later: an=1101, seg=7'b0110000 ("3").
  - Full 4-digit rotation repeats every 16 cycles.
- No tearing: load 16'hFFFF while idx=1 → digits 1–3 keep the old value until frame_done pulses; the new value shows from digit 0 onward.
- Bypass: load_i coincident with the 3→0 tick → new value shown on digit 0 in that same frame; pending stays 0; no extra frame of latency.
- Enable: drop en_i for 10 cycles → an=4'b1111 throughout, no frame_done; re-enable → digit 0 first, boundary after 16 cycles. A load while disabled is applied at that boundary.
- LEADING_ZERO_BLANK_EN defined, load 16'h0050:
  - digits 3 and 2 show an off
  - digit 1 shows seg=7'b0010010 ("5")
  - digit 0 shows seg=7'b1000000 ("0")
  - with the macro undefined, all four anodes assert.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared types and the hex-to-segment table for the 4-digit display scanner.
// Segment vectors are active-high, ordered {g,f,e,d,c,b,a}.
package digit_scan_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] dig_idx_t;

    function automatic seg_t hex7(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_scan_decoder4_dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable (active-high output).
// Ports: idx - digit index in; en - 0 forces all outputs low; onehot - decoded select.
module dec2to4
    import digit_scan_pkg::*;
(
    input  dig_idx_t   idx,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_decoder4.sv
// 4-digit multiplexed 7-segment display driver.
// A prescaler advances the digit index every REFRESH_DIV cycles; the selected
// nibble of the displayed value is decoded onto seg and the index onto an.
// New data is staged in a shadow register and only adopted at a frame
// boundary (index wrap 3->0), so a frame never mixes old and new digits.
// Ports: clk, rst (async active-high), en_i (scan enable, 0 blanks),
//        load_i (capture strobe), data_i (nibble k -> digit k),
//        an (anode select), seg ({g,f,e,d,c,b,a}), dig_idx, frame_done.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits 3..1.
module digit_scan_decoder4
    import digit_scan_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter bit ACTIVE_LOW_AN  = 1'b1,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] data_i,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  dig_idx,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]    AN_OFF  = {4{ACTIVE_LOW_AN}};
    localparam seg_t          SEG_OFF = {7{ACTIVE_LOW_SEG}};

    logic [CW-1:0] cnt_q, cnt_d;
    dig_idx_t      idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pend_q, pend_d;
    logic          tick, boundary;
    logic [3:0]    nib;
    logic [3:0]    show;
    logic [3:0]    onehot;
    logic [3:0]    an_d;
    seg_t          seg_d;

    always_comb begin
        tick     = en_i && (cnt_q == LAST);
        cnt_d    = (!en_i || tick) ? '0 : cnt_q + CW'(1);
        idx_d    = !en_i ? '0 : (tick ? idx_q + 2'd1 : idx_q);
        boundary = tick && (idx_q == 2'd3);

        shadow_d = load_i ? data_i : shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (boundary) begin
            // A load coinciding with the boundary bypasses the shadow so it
            // appears in the frame that starts now.
            if (load_i) begin
                disp_d = data_i;
            end else if (pend_q) begin
                disp_d = shadow_q;
            end
            pend_d = 1'b0;
        end else if (load_i) begin
            pend_d = 1'b1;
        end

        nib = disp_d[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is shown if it or any more significant nibble is nonzero.
        show[3] = |disp_d[15:12];
        show[2] = show[3] | (|disp_d[11:8]);
        show[1] = show[2] | (|disp_d[7:4]);
        show[0] = 1'b1;
`else
        show = '1;
`endif

        an_d  = onehot ^ AN_OFF;
        seg_d = (en_i ? hex7(nib) : seg_t'(0)) ^ SEG_OFF;
    end

    dec2to4 u_dec (
        .idx    (idx_d),
        .en     (en_i & show[idx_d]),
        .onehot (onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            pend_q     <= 1'b0;
            frame_done <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dig_idx    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            frame_done <= boundary;
            an         <= an_d;
            seg        <= seg_d;
            dig_idx    <= idx_d;
        end
    end

endmodule

// File: tb/tb_digit_scan_decoder4.sv
module tb_digit_scan_decoder4;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  dig_idx;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    digit_scan_decoder4 #(
        .REFRESH_DIV    (DIV),
        .ACTIVE_LOW_AN  (1'b1),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .load_i     (load_i),
        .data_i     (data_i),
        .an         (an),
        .seg        (seg),
        .dig_idx    (dig_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Segment table, active-high gfedcba, indexed by hex digit.
    logic [6:0] hexa [0:15] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model: m counts enabled edges since scanning (re)started.
    int          m = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pval = '0;
    bit          m_pend = 1'b0;
    int          m_idx = 0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic [1:0]  e_idx = '0;
    logic        e_fd = 1'b0;

    task automatic model_reset();
        m = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0; m_idx = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_idx = '0; e_fd = 1'b0;
    endtask

    // Drive one clock with the given inputs and advance the model.
    task automatic cyc(input bit e, input bit l, input logic [15:0] d);
        bit          bnd;
        logic [15:0] hi;
        en_i = e; load_i = l; data_i = d;
        @(posedge clk);
        if (e) begin
            m = m + 1;
            bnd = (m % (4 * DIV)) == 0;
        end else begin
            m = 0;
            bnd = 1'b0;
        end
        if (bnd) begin
            m_disp = l ? d : (m_pend ? m_pval : m_disp);
            m_pend = 1'b0;
        end else if (l) begin
            m_pval = d;
            m_pend = 1'b1;
        end
        m_idx = (m / DIV) % 4;
        hi    = m_disp >> (4 * m_idx);
        e_idx = 2'(m_idx);
        e_fd  = bnd;
        e_an  = e ? ~(4'b0001 << m_idx) : 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (e && m_idx > 0 && hi == 16'h0) e_an = 4'hF;
`endif
        e_seg = e ? ~hexa[hi[3:0]] : 7'h7F;
        #1;
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
            n_bad++;
            $display("FAIL reset_initial: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                     an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, '0);
        // Run mid-scan with pending data, then reset asynchronously between edges.
        for (int i = 0; i < 23; i++) cyc(1'b1, (i == 9), 16'hBEEF);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
            n_bad++;
            $display("FAIL reset_async: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                     an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
        end
        en_i = 1'b0;
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, '0);
    endtask

    task automatic test_load_scan();
        cyc(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL load_scan[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    task automatic test_no_tear();
        int guard = 0;
        while (m_idx != 1 && guard < 40) begin
            cyc(1'b1, 1'b0, '0);
            guard++;
        end
        n_cmp++;
        if (m_idx != 1) begin
            n_bad++;
            $display("FAIL no_tear_sync: got model idx=%0d want 1 within 40 cycles", m_idx);
        end
        cyc(1'b1, 1'b1, 16'hFFFF);
        for (int i = 0; i < 36; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL no_tear[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    task automatic test_bypass();
        int guard = 0;
        while (((m + 1) % (4 * DIV)) != 0 && guard < 40) begin
            cyc(1'b1, 1'b0, '0);
            guard++;
        end
        cyc(1'b1, 1'b1, 16'hA5C3);
        n_cmp++;
        if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd} || e_fd !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_edge: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=1",
                     an, seg, dig_idx, frame_done, e_an, e_seg, e_idx);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL bypass[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, (i == 4), 16'h9E07);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL disabled[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=1111 seg=1111111 idx=0 fd=0",
                         i, an, seg, dig_idx, frame_done);
            end
        end
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL reenable[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    task automatic test_lzb();
        cyc(1'b1, 1'b1, 16'h0050);
        for (int i = 0; i < 36; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL lzb[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), 16'($urandom));
            n_cmp++;
            if ({an, seg, dig_idx, frame_done} !== {e_an, e_seg, e_idx, e_fd}) begin
                n_bad++;
                $display("FAIL random[%0d]: got an=%b seg=%b idx=%0d fd=%b want an=%b seg=%b idx=%0d fd=%b",
                         i, an, seg, dig_idx, frame_done, e_an, e_seg, e_idx, e_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_no_tear();
        test_bypass();
        test_enable();
        test_lzb();
        test_random();
        test_lzb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary within 200000 time units");
        $fatal(1);
    end

endmodule
